// File: rtl/csr_file.sv
// Machine-mode CSR storage around the CSR read-modify-write unit.
// Holds the writable machine CSRs and the 64-bit cycle/instret counters.
// Applies trap entry and mret updates to mstatus/mepc/mcause/mtval.
// Reads and the illegal-access flag are combinational, so the CSR unit
// sees the pre-write value in the same cycle.
module csr_file #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h40000100,
  parameter logic [31:0] MTVEC_RST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [11:0] csrAddr,
  input  logic        csrRead,
  input  logic        csrWrite,
  input  logic [31:0] csrWdata,
  output logic [31:0] csrRdata,
  output logic        illegalCsr,
  input  logic        instRetire,
  input  logic        trapTaken,
  input  logic [31:0] trapPc,
  input  logic [31:0] trapCause,
  input  logic [31:0] trapVal,
  input  logic        mretTaken,
  output logic [31:0] mtvecOut,
  output logic [31:0] mepcOut,
  output logic        mieOut
);

  // mstatus image: MPP hardwired to machine mode, only MIE/MPIE stored
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    mstatus_pack = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
  endfunction

  // Clear the two low bits (word-aligned mtvec base and mepc)
  function automatic logic [31:0] word_align(input logic [31:0] v);
    word_align = {v[31:2], 2'b00};
  endfunction

  logic        mie_r;
  logic        mpie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic [31:0] rdata_s;
  logic        implemented_s;
  logic        illegal_s;
  logic        wr_en_s;

  // Address decode: read value and whether the address exists
  always_comb begin
    rdata_s       = 32'd0;
    implemented_s = 1'b1;
    case (csrAddr)
      12'h300: rdata_s = mstatus_pack(mie_r, mpie_r);
      12'h301: rdata_s = MISA_VAL;
      12'h305: rdata_s = mtvec_r;
      12'h340: rdata_s = mscratch_r;
      12'h341: rdata_s = mepc_r;
      12'h342: rdata_s = mcause_r;
      12'h343: rdata_s = mtval_r;
      12'hB00: rdata_s = mcycle_r[31:0];
      12'hB80: rdata_s = mcycle_r[63:32];
      12'hB02: rdata_s = minstret_r[31:0];
      12'hB82: rdata_s = minstret_r[63:32];
      12'hC00: rdata_s = mcycle_r[31:0];
      12'hC80: rdata_s = mcycle_r[63:32];
      12'hC02: rdata_s = minstret_r[31:0];
      12'hC82: rdata_s = minstret_r[63:32];
      12'hF14: rdata_s = HART_ID;
      default: begin
        rdata_s       = 32'd0;
        implemented_s = 1'b0;
      end
    endcase
  end

  // Illegal access detection and the qualified write enable
  always_comb begin
    illegal_s = ((csrRead | csrWrite) & ~implemented_s) |
                (csrWrite & (csrAddr[11:10] == 2'b11));
    wr_en_s   = csrWrite & ~illegal_s & ~trapTaken;
  end

  assign csrRdata   = rdata_s;
  assign illegalCsr = illegal_s;
  assign mtvecOut   = mtvec_r;
  assign mepcOut    = mepc_r;
  assign mieOut     = mie_r;

  // Trap entry, mret and software writes to the machine CSRs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= MTVEC_RST;
      mscratch_r <= 32'd0;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
      mtval_r    <= 32'd0;
    end else if (trapTaken) begin
      mepc_r   <= word_align(trapPc);
      mcause_r <= trapCause;
      mtval_r  <= trapVal;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else begin
      // mret owns MIE/MPIE even if mstatus is written in the same cycle
      if (mretTaken) begin
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
      end else if (wr_en_s && (csrAddr == 12'h300)) begin
        mie_r  <= csrWdata[3];
        mpie_r <= csrWdata[7];
      end else begin
        mie_r  <= mie_r;
        mpie_r <= mpie_r;
      end
      if (wr_en_s) begin
        case (csrAddr)
          12'h305: mtvec_r    <= word_align(csrWdata);
          12'h340: mscratch_r <= csrWdata;
          12'h341: mepc_r     <= word_align(csrWdata);
          12'h342: mcause_r   <= csrWdata;
          12'h343: mtval_r    <= csrWdata;
          default: ;
        endcase
      end
    end
  end

  // 64-bit counters; a write to one half freezes the whole counter that cycle
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      if (wr_en_s && (csrAddr == 12'hB00)) begin
        mcycle_r[31:0] <= csrWdata;
      end else if (wr_en_s && (csrAddr == 12'hB80)) begin
        mcycle_r[63:32] <= csrWdata;
      end else begin
        mcycle_r <= mcycle_r + 64'd1;
      end
      if (wr_en_s && (csrAddr == 12'hB02)) begin
        minstret_r[31:0] <= csrWdata;
      end else if (wr_en_s && (csrAddr == 12'hB82)) begin
        minstret_r[63:32] <= csrWdata;
      end else if (instRetire) begin
        minstret_r <= minstret_r + 64'd1;
      end else begin
        minstret_r <= minstret_r;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file. Stimulus pushes tagged expectations into a
// scoreboard queue; a negedge monitor pops and compares those due this cycle.
module tb_csr_file;

  logic        clk;
  logic        rstN;
  logic [11:0] csrAddr;
  logic        csrRead;
  logic        csrWrite;
  logic [31:0] csrWdata;
  logic [31:0] csrRdata;
  logic        illegalCsr;
  logic        instRetire;
  logic        trapTaken;
  logic [31:0] trapPc;
  logic [31:0] trapCause;
  logic [31:0] trapVal;
  logic        mretTaken;
  logic [31:0] mtvecOut;
  logic [31:0] mepcOut;
  logic        mieOut;

  csr_file dut (
    .clk        (clk),
    .rstN       (rstN),
    .csrAddr    (csrAddr),
    .csrRead    (csrRead),
    .csrWrite   (csrWrite),
    .csrWdata   (csrWdata),
    .csrRdata   (csrRdata),
    .illegalCsr (illegalCsr),
    .instRetire (instRetire),
    .trapTaken  (trapTaken),
    .trapPc     (trapPc),
    .trapCause  (trapCause),
    .trapVal    (trapVal),
    .mretTaken  (mretTaken),
    .mtvecOut   (mtvecOut),
    .mepcOut    (mepcOut),
    .mieOut     (mieOut)
  );

  localparam int SEL_RDATA = 0;
  localparam int SEL_ILL   = 1;
  localparam int SEL_MTVEC = 2;
  localparam int SEL_MEPC  = 3;
  localparam int SEL_MIE   = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    cyc;
  int    checks;
  int    errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to tag expectations
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compare every expectation due in this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      item_t it;
      logic [31:0] act;
      it = q.pop_front();
      case (it.sel)
        SEL_RDATA: act = csrRdata;
        SEL_ILL:   act = {31'd0, illegalCsr};
        SEL_MTVEC: act = mtvecOut;
        SEL_MEPC:  act = mepcOut;
        default:   act = {31'd0, mieOut};
      endcase
      checks = checks + 1;
      if (it.cyc != cyc || act !== it.exp) begin
        errors = errors + 1;
        $display("FAIL %s cyc %0d (due %0d) got %h expected %h", it.name, cyc, it.cyc, act, it.exp);
      end
    end
  end

  task automatic expect_out(input int sel, input logic [31:0] exp, input string name);
    item_t it;
    it.cyc  = cyc;
    it.sel  = sel;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
  endtask

  // Advance one cycle and drop all strobes
  task automatic step();
    @(posedge clk);
    #1;
    csrRead    = 1'b0;
    csrWrite   = 1'b0;
    instRetire = 1'b0;
    trapTaken  = 1'b0;
    mretTaken  = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic ill, input string name);
    csrAddr  = a;
    csrRead  = 1'b1;
    csrWrite = 1'b0;
    expect_out(SEL_RDATA, exp, name);
    expect_out(SEL_ILL, {31'd0, ill}, {name, "_ill"});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ill, input string name);
    csrAddr  = a;
    csrWdata = d;
    csrWrite = 1'b1;
    csrRead  = 1'b0;
    expect_out(SEL_ILL, {31'd0, ill}, name);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rstN       = 1'b0;
    csrAddr    = 12'd0;
    csrRead    = 1'b0;
    csrWrite   = 1'b0;
    csrWdata   = 32'd0;
    instRetire = 1'b0;
    trapTaken  = 1'b0;
    trapPc     = 32'd0;
    trapCause  = 32'd0;
    trapVal    = 32'd0;
    mretTaken  = 1'b0;

    // Reset state
    step();
    expect_out(SEL_MTVEC, 32'h0, "rst_mtvec");
    expect_out(SEL_MEPC,  32'h0, "rst_mepc");
    expect_out(SEL_MIE,   32'h0, "rst_mie");
    rd(12'hB00, 32'd0, 1'b0, "rst_mcycle");
    step();
    rstN = 1'b1;

    // Five idle cycles after release
    for (int i = 0; i < 5; i++) step();
    rd(12'hB00, 32'd5, 1'b0, "mcycle_5");
    expect_out(SEL_MIE,   32'h0, "idle_mie");
    expect_out(SEL_MTVEC, 32'h0, "idle_mtvec");
    step();
    rd(12'hB80, 32'd0, 1'b0, "mcycleh_0");
    step();

    // mtvec alignment
    wr(12'h305, 32'h80000107, 1'b0, "wr_mtvec");
    step();
    expect_out(SEL_MTVEC, 32'h80000104, "mtvec_out");
    rd(12'h305, 32'h80000104, 1'b0, "rd_mtvec");
    step();

    // Read-only cycle write is illegal and does not load
    wr(12'hB00, 32'd100, 1'b0, "wr_mcycle100");
    step();
    wr(12'hC00, 32'd5, 1'b1, "wr_cycle_ill");
    step();
    rd(12'hC00, 32'd101, 1'b0, "cycle_101");
    step();
    rd(12'hC80, 32'd0, 1'b0, "cycleh_0");
    step();
    rd(12'h7C0, 32'd0, 1'b1, "rd_unimpl");
    step();
    wr(12'hF14, 32'd7, 1'b1, "wr_hartid_ill");
    step();
    rd(12'hF14, 32'd0, 1'b0, "rd_hartid");
    step();
    wr(12'h301, 32'd0, 1'b0, "wr_misa");
    step();
    rd(12'h301, 32'h40000100, 1'b0, "rd_misa");
    step();

    // Trap entry, dropped concurrent write, mret
    wr(12'h340, 32'h55, 1'b0, "wr_mscratch");
    step();
    wr(12'h343, 32'h77, 1'b0, "wr_mtval");
    step();
    wr(12'h300, 32'h8, 1'b0, "wr_mstatus");
    step();
    expect_out(SEL_MIE, 32'h1, "mie_set");
    trapTaken = 1'b1;
    trapPc    = 32'h103;
    trapCause = 32'hB;
    trapVal   = 32'h0;
    wr(12'h340, 32'hAA, 1'b0, "wr_during_trap");
    step();
    expect_out(SEL_MEPC, 32'h100, "trap_mepc");
    expect_out(SEL_MIE,  32'h0,   "trap_mie");
    rd(12'h342, 32'hB, 1'b0, "trap_mcause");
    step();
    rd(12'h300, 32'h1880, 1'b0, "trap_mstatus");
    step();
    rd(12'h343, 32'h0, 1'b0, "trap_mtval");
    step();
    rd(12'h340, 32'h55, 1'b0, "mscratch_kept");
    step();
    mretTaken = 1'b1;
    step();
    expect_out(SEL_MIE, 32'h1, "mret_mie");
    rd(12'h300, 32'h1888, 1'b0, "mret_mstatus");
    step();
    mretTaken = 1'b1;
    wr(12'h300, 32'h0, 1'b0, "wr_mstatus_mret");
    step();
    expect_out(SEL_MIE, 32'h1, "mret_wins_mie");
    rd(12'h300, 32'h1888, 1'b0, "mret_wins_mstatus");
    step();
    trapTaken = 1'b1;
    mretTaken = 1'b1;
    trapPc    = 32'h202;
    trapCause = 32'h3;
    trapVal   = 32'h44;
    step();
    expect_out(SEL_MIE,  32'h0,   "trapmret_mie");
    expect_out(SEL_MEPC, 32'h200, "trapmret_mepc");
    rd(12'h300, 32'h1880, 1'b0, "trapmret_mstatus");
    step();
    rd(12'h343, 32'h44, 1'b0, "trapmret_mtval");
    step();
    wr(12'h341, 32'h13, 1'b0, "wr_mepc");
    step();
    expect_out(SEL_MEPC, 32'h10, "mepc_align_out");
    rd(12'h341, 32'h10, 1'b0, "mepc_align_rd");
    step();

    // mcycle carry from low into high half
    wr(12'hB00, 32'hFFFFFFFF, 1'b0, "wr_mcycle_lo");
    step();
    wr(12'hB80, 32'h0, 1'b0, "wr_mcycle_hi");
    step();
    step();
    rd(12'hB00, 32'h0, 1'b0, "carry_lo");
    step();
    rd(12'hB80, 32'h1, 1'b0, "carry_hi");
    step();

    // mcycle full 64-bit wrap
    wr(12'hB00, 32'hFFFFFFFF, 1'b0, "wr_wrap_lo");
    step();
    wr(12'hB80, 32'hFFFFFFFF, 1'b0, "wr_wrap_hi");
    step();
    step();
    rd(12'hB80, 32'h0, 1'b0, "wrap_hi");
    step();
    rd(12'hB00, 32'h1, 1'b0, "wrap_lo");
    step();

    // minstret write wins over instRetire
    instRetire = 1'b1;
    wr(12'hB02, 32'h10, 1'b0, "wr_minstret");
    step();
    rd(12'hB02, 32'h10, 1'b0, "minstret_10");
    instRetire = 1'b1;
    step();
    rd(12'hC02, 32'h11, 1'b0, "instret_11");
    step();
    rd(12'hB82, 32'h0, 1'b0, "minstreth_0");
    step();

    // Reset mid-operation clears state immediately
    wr(12'h300, 32'h8, 1'b0, "wr_mstatus_pre_rst");
    step();
    rstN = 1'b0;
    rd(12'hB00, 32'h0, 1'b0, "midrst_mcycle");
    expect_out(SEL_MTVEC, 32'h0, "midrst_mtvec");
    expect_out(SEL_MEPC,  32'h0, "midrst_mepc");
    expect_out(SEL_MIE,   32'h0, "midrst_mie");
    step();
    rd(12'hB02, 32'h0, 1'b0, "midrst_minstret");
    step();
    rstN = 1'b1;
    step();
    step();

    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR storage stage sitting directly around the CSR read-modify-write unit.
- Supplies the current CSR value to the unit combinationally (`csrRdata`).
- Commits the unit's `csrResult` on `csrWrite`.
- Maintains the cycle/instret counters and the trap/mret state updates used by the fetch redirect logic.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- MISA_VAL, 32'h40000100, read-only misa value (RV32I).
- MTVEC_RST, 32'h00000000, reset value of mtvec.

Ports:
- clk  input  1  core clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- csrAddr  input  12  CSR address from instruction bits 31:20.
- csrRead  input  1  read strobe from CSR unit.
- csrWrite  input  1  write strobe from CSR unit.
- csrWdata  input  32  new CSR value (CSR unit csrResult).
- csrRdata  output  32  current value of addressed CSR, combinational.
- illegalCsr  output  1  access to unimplemented CSR, or write to read-only CSR.
- instRetire  input  1  one instruction retires this cycle.
- trapTaken  input  1  enter trap this cycle.
- trapPc  input  32  PC of trapping instruction.
- trapCause  input  32  mcause value for trap.
- trapVal  input  32  mtval value for trap.
- mretTaken  input  1  mret retires this cycle.
- mtvecOut  output  32  registered mtvec, base of trap vector.
- mepcOut  output  32  registered mepc, mret target.
- mieOut  output  1  registered mstatus.MIE.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP bits12:11 hardwired 2'b11, all other bits read 0.
  - misa 0x301: read-only, writes ignored, not illegal.
  - mtvec 0x305: bits1:0 forced 0, direct mode only.
  - mscratch 0x340.
  - mepc 0x341: bits1:0 forced 0.
  - mcause 0x342.
  - mtval 0x343.
  - mcycle 0xB00, mcycleh 0xB80.
  - minstret 0xB02, minstreth 0xB82.
  - Read-only: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82, mhartid 0xF14.
- Read: `csrRdata` is a pure combinational mux on `csrAddr`. It returns 0 for unimplemented addresses. Zero-latency, so the CSR unit sees the old value in the same cycle.
- illegalCsr (combinational):
  - Asserted when (csrRead | csrWrite) and the address is unimplemented.
  - Asserted when csrWrite and csrAddr[11:10]==2'b11 (read-only space).
  - Otherwise 0.
  - When asserted, no CSR state changes from the access.
- Write: on the rising edge when csrWrite & ~illegalCsr & ~trapTaken, the addressed register takes csrWdata, with masking as listed above.
- mcycle:
  - 64-bit, +1 every cycle out of reset, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A write to one half in a cycle loads that half with csrWdata. The other half holds: no increment and no carry that cycle.
- minstret:
  - 64-bit, +1 on instRetire, same wrap rule.
  - A write to either half wins over instRetire in the same cycle, using the same hold rule as mcycle.
- Trap (trapTaken=1) on the next edge:
  - mepc <= trapPc & ~3.
  - mcause <= trapCause.
  - mtval <= trapVal.
  - MPIE <= MIE, MIE <= 0.
  - A concurrent csrWrite is dropped.
  - Counters still increment.
- mret (mretTaken=1, trapTaken=0): MIE <= MPIE, MPIE <= 1.
- trapTaken & mretTaken in the same cycle: trap wins and mret is ignored.
- mretTaken & csrWrite to mstatus in the same cycle: mret wins for MIE/MPIE.
- Reset (async, rstN=0): all registers 0 except mtvec=MTVEC_RST. Outputs at reset: mtvecOut=MTVEC_RST, mepcOut=0, mieOut=0, mcycle=0. Reset mid-operation aborts any pending update immediately.
- mtvecOut, mepcOut and mieOut are direct register outputs and reflect a write one cycle after the write edge.

Test Plan:
- Reset, release rstN, idle 5 cycles -> read 0xB00 returns 5, read 0xB80 returns 0, mieOut=0, mtvecOut=0.
- csrWrite 0x305 with 0x80000107 -> mtvecOut=0x80000104 next cycle. csrWrite 0xC00 -> illegalCsr=1 and cycle unchanged. csrRead 0x7C0 -> illegalCsr=1, csrRdata=0.
- Write mstatus=0x8; same cycle as trapTaken with trapPc=0x103, trapCause=0xB, trapVal=0 -> mepcOut=0x100, mcause=0xB, mieOut=0, mstatus bit7=1; next cycle mretTaken -> mieOut=1, MPIE=1.
- Write mcycle=0xFFFFFFFF and mcycleh=0 -> after 1 cycle mcycleh=1, mcycle=0. Write both halves to 0xFFFFFFFF -> next count wraps both to 0.
- instRetire=1 while writing minstret=0x10 -> minstret=0x10, not 0x11; next instRetire -> 0x11.
- Assert trapTaken and mretTaken together with MIE=1 -> MIE=0, MPIE=1. Pulse rstN low mid-count -> all counters read 0 immediately.
